// File: rtl/complex_alu_pkg.sv
// Shared types, opcodes and packing helpers for the complex-number ALU.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package complex_alu_pkg;

  localparam int DW_DEF = 8;   // operand component width
  localparam int RW_DEF = 24;  // result component width, >= 2*DW_DEF+1

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    MUL2 = 2'd2
  } state_e;

  // Operand word as carried on m1/m2: real in the upper half, imag in the lower.
  typedef struct packed {
    logic [DW_DEF-1:0] re;
    logic [DW_DEF-1:0] im;
  } cplx_op_t;

  function automatic cplx_op_t unpack_op(input logic [2*DW_DEF-1:0] w);
    cplx_op_t c;
    c.re = w[2*DW_DEF-1:DW_DEF];
    c.im = w[DW_DEF-1:0];
    return c;
  endfunction

  function automatic logic [2*RW_DEF-1:0] pack_res(input logic [RW_DEF-1:0] re,
                                                   input logic [RW_DEF-1:0] im);
    return {re, im};
  endfunction

endpackage

// File: rtl/complex_alu_mul.sv
// Complex multiply: four partial products registered on load_i, combined combinationally.
// Latency: products valid one edge after load_i; re_o/im_o follow the product registers.
// Backpressure: none; the controller decides when the combined value is consumed.
module complex_alu_mul
  import complex_alu_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int RW = RW_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_i,
  input  logic signed [DW-1:0] ar_i,
  input  logic signed [DW-1:0] ai_i,
  input  logic signed [DW-1:0] br_i,
  input  logic signed [DW-1:0] bi_i,
  output logic signed [RW-1:0] re_o,
  output logic signed [RW-1:0] im_o
);

  localparam int PW = 2 * DW;  // exact signed product width
  localparam int SW = PW + 1;  // sum/difference of two products

  logic signed [PW-1:0] p_rr_q, p_ii_q, p_ri_q, p_ir_q;
  logic signed [PW-1:0] p_rr_d, p_ii_d, p_ri_d, p_ir_d;
  logic signed [SW-1:0] re_s, im_s;

  // Operands widened before multiplying so the product is computed at full width.
  always_comb begin
    p_rr_d = PW'(ar_i) * PW'(br_i);
    p_ii_d = PW'(ai_i) * PW'(bi_i);
    p_ri_d = PW'(ar_i) * PW'(bi_i);
    p_ir_d = PW'(ai_i) * PW'(br_i);
  end

  // Product registers, captured only when the FSM is in EXEC with a multiply.
  always_ff @(posedge clk) begin
    if (rst) begin
      p_rr_q <= '0;
      p_ii_q <= '0;
      p_ri_q <= '0;
      p_ir_q <= '0;
    end else if (load_i) begin
      p_rr_q <= p_rr_d;
      p_ii_q <= p_ii_d;
      p_ri_q <= p_ri_d;
      p_ir_q <= p_ir_d;
    end
  end

  // Combine in SW bits (-128*-128 twice reaches +32768), then sign-extend.
  always_comb begin
    re_s = SW'(p_rr_q) - SW'(p_ii_q);
    im_s = SW'(p_ri_q) + SW'(p_ir_q);
    re_o = RW'(re_s);
    im_o = RW'(im_s);
  end

endmodule

// File: rtl/complex_alu.sv
// Registered complex add/sub/mul on packed 8+8-bit operands, 24+24-bit result.
// Latency: add/sub/reserved 1 edge after acceptance, multiply 2 edges.
// Backpressure: start is only honoured in IDLE; requests while busy are silently ignored.
module complex_alu
  import complex_alu_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int RW = RW_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      operation,
  input  logic            a_valid,
  input  logic            b_valid,
  input  logic            start,
  input  logic [2*DW-1:0] m1,
  input  logic [2*DW-1:0] m2,
  output logic            valid,
  output logic            error,
  output logic [2*RW-1:0] result
);

  state_e          state_q, state_d;
  logic [2*DW-1:0] a_q, a_d, b_q, b_d;
  logic [1:0]      op_q, op_d;
  logic            valid_q, valid_d;
  logic            error_q, error_d;
  logic [2*RW-1:0] result_q, result_d;
  logic            mul_load;

  cplx_op_t             a_c, b_c;
  logic signed [RW-1:0] add_re, add_im, sub_re, sub_im;
  logic signed [RW-1:0] mul_re, mul_im;

  // Add/sub path works on the latched operands, so input changes after acceptance are harmless.
  always_comb begin
    a_c    = unpack_op(a_q);
    b_c    = unpack_op(b_q);
    add_re = RW'($signed(a_c.re)) + RW'($signed(b_c.re));
    add_im = RW'($signed(a_c.im)) + RW'($signed(b_c.im));
    sub_re = RW'($signed(a_c.re)) - RW'($signed(b_c.re));
    sub_im = RW'($signed(a_c.im)) - RW'($signed(b_c.im));
  end

  complex_alu_mul #(
    .DW(DW),
    .RW(RW)
  ) u_mul (
    .clk    (clk),
    .rst    (rst),
    .load_i (mul_load),
    .ar_i   ($signed(a_c.re)),
    .ai_i   ($signed(a_c.im)),
    .br_i   ($signed(b_c.re)),
    .bi_i   ($signed(b_c.im)),
    .re_o   (mul_re),
    .im_o   (mul_im)
  );

  // Next-state, operand latching and output computation.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    valid_d  = 1'b0;
    error_d  = 1'b0;
    result_d = result_q;
    mul_load = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (a_valid && b_valid) begin
            a_d     = m1;
            b_d     = m2;
            op_d    = operation;
            state_d = EXEC;
          end else begin
            error_d = 1'b1;
          end
        end
      end
      EXEC: begin
        unique case (op_q)
          OP_ADD: begin
            result_d = pack_res(add_re, add_im);
            valid_d  = 1'b1;
            state_d  = IDLE;
          end
          OP_SUB: begin
            result_d = pack_res(sub_re, sub_im);
            valid_d  = 1'b1;
            state_d  = IDLE;
          end
          OP_MUL: begin
            mul_load = 1'b1;
            state_d  = MUL2;
          end
          default: begin
            // Reserved opcode completes immediately with a zero result and both pulses.
            result_d = '0;
            valid_d  = 1'b1;
            error_d  = 1'b1;
            state_d  = IDLE;
          end
        endcase
      end
      MUL2: begin
        result_d = pack_res(mul_re, mul_im);
        valid_d  = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, latched operands and output registers; reset aborts any operation silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= OP_ADD;
      valid_q  <= 1'b0;
      error_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      valid_q  <= valid_d;
      error_q  <= error_d;
      result_q <= result_d;
    end
  end

  assign valid  = valid_q;
  assign error  = error_q;
  assign result = result_q;

endmodule

// File: tb/tb_complex_alu.sv
// Directed bench for complex_alu: each scenario task drives vectors and checks inline.
// Latency: n/a.
// Backpressure: n/a.
module tb_complex_alu;

  logic        clk;
  logic        rst;
  logic [1:0]  operation;
  logic        a_valid;
  logic        b_valid;
  logic        start;
  logic [15:0] m1;
  logic [15:0] m2;
  logic        valid;
  logic        error;
  logic [47:0] result;

  int checks = 0;
  int errors = 0;

  localparam logic [47:0] R_ADD  = 48'h000004_000006;
  localparam logic [47:0] R_SUB  = 48'h000002_FFFFFE;
  localparam logic [47:0] R_MUL  = 48'hFFFFFB_00000E;
  localparam logic [47:0] R_MMUL = 48'h000000_008000;
  localparam logic [47:0] R_MADD = 48'hFFFF00_FFFF00;

  complex_alu dut (
    .clk       (clk),
    .rst       (rst),
    .operation (operation),
    .a_valid   (a_valid),
    .b_valid   (b_valid),
    .start     (start),
    .m1        (m1),
    .m2        (m2),
    .valid     (valid),
    .error     (error),
    .result    (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
    operation = 2'b00; m1 = '0; m2 = '0;
    tick(); tick();
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL reset_error: got %b want 0", error); end
    checks++; if (result !== 48'h0) begin errors++; $display("FAIL reset_result: got %h want 0", result); end
    rst = 1'b0;
    tick();
  endtask

  // Single-cycle op: accept at E0, result at E1, pulse gone at E2.
  task automatic test_addsub(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                             input logic [47:0] exp);
    m1 = a; m2 = b; operation = op; a_valid = 1'b1; b_valid = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL addsub_early op=%0d: valid %b want 0", op, valid); end
    tick();
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL addsub_valid op=%0d: got %b want 1", op, valid); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL addsub_error op=%0d: got %b want 0", op, error); end
    checks++; if (result !== exp) begin errors++; $display("FAIL addsub_result op=%0d: got %h want %h", op, result, exp); end
    tick();
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL addsub_pulse op=%0d: valid %b want 0", op, valid); end
  endtask

  // Multiply; inputs are scrambled and start is held with bad valids while busy.
  task automatic test_mul(input logic [15:0] a, input logic [15:0] b, input logic [47:0] exp);
    m1 = a; m2 = b; operation = 2'b10; a_valid = 1'b1; b_valid = 1'b1; start = 1'b1;
    tick();
    m1 = 16'h7F7F; m2 = 16'h1234; operation = 2'b00; a_valid = 1'b0;
    tick();
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL mul_early: valid %b want 0", valid); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL mul_busy_error: got %b want 0", error); end
    tick();
    start = 1'b0;
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL mul_valid: got %b want 1", valid); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL mul_error: got %b want 0", error); end
    checks++; if (result !== exp) begin errors++; $display("FAIL mul_result: got %h want %h", result, exp); end
    tick();
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL mul_pulse: valid %b want 0", valid); end
  endtask

  // Rejected request: result must keep the previous add of 8080+8080.
  task automatic test_error();
    m1 = 16'h0302; m2 = 16'h0104; operation = 2'b00;
    a_valid = 1'b0; b_valid = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL reject_error: got %b want 1", error); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reject_valid: got %b want 0", valid); end
    checks++; if (result !== R_MADD) begin errors++; $display("FAIL reject_result: got %h want %h", result, R_MADD); end
    tick();
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL reject_pulse: error %b want 0", error); end
    // A rejected request must not leave anything in flight.
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reject_noop: valid %b want 0", valid); end
  endtask

  task automatic test_reserved();
    m1 = 16'h0302; m2 = 16'h0104; operation = 2'b11;
    a_valid = 1'b1; b_valid = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL rsv_valid: got %b want 1", valid); end
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL rsv_error: got %b want 1", error); end
    checks++; if (result !== 48'h0) begin errors++; $display("FAIL rsv_result: got %h want 0", result); end
    tick();
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL rsv_pulse: error %b want 0", error); end
  endtask

  // start held high; op 00 for edges 0-4, 01 for 5-9, 10 from 10.
  task automatic test_back_to_back();
    logic        exp_v;
    logic [47:0] exp_r;
    m1 = 16'h0302; m2 = 16'h0104; a_valid = 1'b1; b_valid = 1'b1; start = 1'b1;
    for (int k = 0; k <= 18; k++) begin
      operation = (k < 5) ? 2'b00 : (k < 10) ? 2'b01 : 2'b10;
      tick();
      exp_v = (k == 1) || (k == 3) || (k == 5) || (k == 7) || (k == 9) ||
              (k == 12) || (k == 15) || (k == 18);
      exp_r = (k <= 5) ? R_ADD : (k <= 9) ? R_SUB : R_MUL;
      checks++;
      if (valid !== exp_v) begin
        errors++; $display("FAIL b2b_valid edge=%0d: got %b want %b", k, valid, exp_v);
      end
      if (exp_v) begin
        checks++;
        if (result !== exp_r) begin
          errors++; $display("FAIL b2b_result edge=%0d: got %h want %h", k, result, exp_r);
        end
      end
    end
    start = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_mul();
    m1 = 16'h0302; m2 = 16'h0104; operation = 2'b10;
    a_valid = 1'b1; b_valid = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rstmul_pre: valid %b want 0", valid); end
    rst = 1'b1;
    tick();
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rstmul_valid: got %b want 0", valid); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL rstmul_error: got %b want 0", error); end
    checks++; if (result !== 48'h0) begin errors++; $display("FAIL rstmul_result: got %h want 0", result); end
    rst = 1'b0;
    tick();
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rstmul_after: valid %b want 0", valid); end
  endtask

  initial begin
    test_reset();
    test_addsub(2'b00, 16'h0302, 16'h0104, R_ADD);
    test_addsub(2'b01, 16'h0302, 16'h0104, R_SUB);
    test_mul(16'h0302, 16'h0104, R_MUL);
    test_mul(16'h8080, 16'h8080, R_MMUL);
    test_addsub(2'b00, 16'h8080, 16'h8080, R_MADD);
    test_error();
    test_reserved();
    test_back_to_back();
    test_reset_mid_mul();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/complex_alu.md
Name: complex_alu

Overview:
- Registered complex-number ALU: two complex operands packed in 16-bit words; add, subtract or multiply selected by a 2-bit opcode.
- Each 16-bit operand is an 8-bit signed real part and an 8-bit signed imaginary part.
- Produces a 48-bit packed complex result: 24-bit signed real, 24-bit signed imaginary.
- Sits as a datapath leaf, driven by a controller through a start / a_valid / b_valid handshake; reports completion with a valid pulse and misuse with an error pulse.

Parameters:
- DW, 8, width of each operand component (real/imag), signed two's complement.
- RW, 24, width of each result component; must be at least 2*DW+1.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- operation  in  2  00 add, 01 subtract, 10 multiply, 11 reserved
- a_valid  in  1  m1 holds a valid operand
- b_valid  in  1  m2 holds a valid operand
- start  in  1  request an operation
- m1  in  16  operand A: [15:8] real, [7:0] imag
- m2  in  16  operand B: same packing
- valid  out  1  one-cycle pulse, result updated
- error  out  1  one-cycle pulse, request rejected or opcode reserved
- result  out  48  [47:24] real, [23:0] imag, signed, sign-extended

Behaviour:
- Reset, synchronous: state=IDLE, valid=0, error=0, result=0. Reset mid-operation aborts the operation with no valid or error pulse.
- States: IDLE, EXEC, MUL2.
- IDLE, start=1 and a_valid=1 and b_valid=1 at edge E0: latch m1, m2 and operation, go to EXEC.
- IDLE, start=1 with a_valid=0 or b_valid=0: error=1 for one cycle, stay in IDLE, nothing latched, result unchanged.
- IDLE, start=0: hold.
- EXEC at edge E1, by latched op:
  - add: re=Ar+Br, im=Ai+Bi; result registered, valid=1, go to IDLE.
  - sub: re=Ar-Br, im=Ai-Bi; same timing as add.
  - mul: register the four 16-bit signed products Ar*Br, Ai*Bi, Ar*Bi, Ai*Br; go to MUL2.
  - op 11: result=0, valid=1, error=1, go to IDLE.
- MUL2 at edge E2: re=ArBr-AiBi, im=ArBi+AiBr, computed in 17 bits, sign-extended to RW; valid=1, go to IDLE.
- Latency: add/sub/reserved, outputs registered 1 edge after acceptance; mul, 2 edges.
- valid and error are registered pulses and clear at the next edge.
- result holds its last value until the next completion.
- start held high with valid inputs re-accepts on the edge after valid rises. Throughput: one op per 2 cycles for add/sub, per 3 cycles for mul.
- m1, m2 and operation changes after acceptance do not affect the in-flight operation.
- No overflow is possible: 8-bit add/sub fits in 9 bits; the worst-case product sum 32768 fits in 17 bits.
- start is ignored in EXEC and MUL2, with no error raised.

Decomposition:
- Package complex_alu_pkg:
  - opcode constants OP_ADD=2'b00, OP_SUB=2'b01, OP_MUL=2'b10, OP_RSV=2'b11
  - state enum {IDLE, EXEC, MUL2}
  - DW/RW defaults
  - helper functions to unpack a 16-bit operand into real/imag and pack a result
- One sub-module, complex_alu_mul: registered four-product stage plus MUL2 combine (re/im sign-extended). The top module holds the FSM, add/sub path and output registers.

Test Plan:
- Reset, then m1=16'h0302 (3+2i), m2=16'h0104 (1+4i), op=00, all valids=1, start=1 -> one edge later valid=1, result=48'h000004_000006, error=0.
- Same operands, op=01 -> result=48'h000002_FFFFFE (2-2i) after 1 edge.
- Same operands, op=10 -> valid exactly 2 edges after acceptance, result=48'hFFFFFB_00000E (-5+14i).
- m1=m2=16'h8080, op=10 -> result=48'h000000_008000; m1=m2=16'h8080, op=00 -> 48'hFFFF00_FFFF00.
- start=1, a_valid=0, b_valid=1 -> error=1 for one cycle, valid=0, result unchanged; op=11 with valid inputs -> valid=1, error=1, result=0.
- start held high, op changes 00->01->10 every 5 cycles (m1=16'h0302, m2=16'h0104) -> valid pulses every 2 cycles for add/sub and every 3 for mul, results as above; assert rst during MUL2 -> no valid pulse, outputs 0 after the edge.
